// File: rtl/hier_path_decoder.sv
// Reassembles a serial root-first digit stream into a packed instance path; path is valid the cycle after the s_last digit is accepted.
// Backpressure: s_ready stays low while a completed path is held for m_ready, so no digit can be lost while the output is stalled.
module hier_path_decoder #(
  parameter int DEPTH   = 10,
  parameter int FANOUT  = 5,
  parameter int DIGIT_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DIGIT_W-1:0]           s_digit,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DEPTH*DIGIT_W-1:0]     m_path,
  output logic [$clog2(DEPTH+1)-1:0]   m_depth,
  output logic                         m_err_range,
  output logic                         m_err_len,
  output logic [CNT_W-1:0]             path_cnt
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  // One extra bit so a FANOUT equal to 2**DIGIT_W does not wrap to zero.
  localparam logic [DIGIT_W:0] FANOUT_L = (DIGIT_W + 1)'(FANOUT);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state;
  logic [LVL_W-1:0] level;
  logic             accept;
  logic             digit_bad;

  assign accept    = s_valid && s_ready;
  assign digit_bad = {1'b0, s_digit} >= FANOUT_L;
  assign m_depth   = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_path      <= '0;
      level       <= '0;
      m_err_range <= 1'b0;
      m_err_len   <= 1'b0;
      path_cnt    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            // Digits beyond the last slot are dropped; only the length error records them.
            if (level < LVL_MAX) begin
              m_path[int'(level)*DIGIT_W +: DIGIT_W] <= s_digit;
              level <= level + 1'b1;
            end else begin
              m_err_len <= 1'b1;
            end
            if (digit_bad) m_err_range <= 1'b1;
            if (s_last) begin
              state   <= HOLD;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            if (!m_err_range && !m_err_len && path_cnt != '1)
              path_cnt <= path_cnt + 1'b1;
            state       <= COLLECT;
            s_ready     <= 1'b1;
            m_valid     <= 1'b0;
            m_path      <= '0;
            level       <= '0;
            m_err_range <= 1'b0;
            m_err_len   <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hier_path_decoder.sv
// Scoreboarded bench for hier_path_decoder: expected paths are modelled when digits are sent and compared on delivery.
module tb_hier_path_decoder;
  localparam int DEPTH   = 10;
  localparam int FANOUT  = 5;
  localparam int DIGIT_W = 3;
  localparam int CNT_W   = 16;
  localparam int PW      = DEPTH * DIGIT_W;
  localparam int DW      = $clog2(DEPTH + 1);
  localparam int BOUND   = 100;

  typedef struct packed {
    logic [PW-1:0] path;
    logic [DW-1:0] depth;
    logic          err_range;
    logic          err_len;
  } res_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DIGIT_W-1:0] s_digit;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [PW-1:0]      m_path;
  logic [DW-1:0]      m_depth;
  logic               m_err_range;
  logic               m_err_len;
  logic [CNT_W-1:0]   path_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  int   first_stall;
  res_t sb[$];

  hier_path_decoder #(.DEPTH(DEPTH), .FANOUT(FANOUT), .DIGIT_W(DIGIT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_digit(s_digit),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_path(m_path),
    .m_depth(m_depth), .m_err_range(m_err_range), .m_err_len(m_err_len), .path_cnt(path_cnt)
  );

  always #5 clk = ~clk;

  // Drive one digit and return #1 after the edge that accepted it.
  task automatic send(input int d, input bit last, output int stalls);
    s_valid = 1'b1;
    s_digit = DIGIT_W'(d);
    s_last  = last;
    stalls  = 0;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      stalls++;
      if (stalls > BOUND) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: s_ready=%b required=1 within %0d cycles", s_ready, BOUND);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Model the delivered result, push it, then stream the digits back-to-back.
  task automatic send_path(input int d[$], input bit last_at_end);
    res_t e;
    int   st;
    e = '0;
    foreach (d[i]) begin
      if (i < DEPTH) begin
        e.path[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(d[i]);
        e.depth = DW'(i + 1);
      end else begin
        e.err_len = 1'b1;
      end
      if (d[i] >= FANOUT) e.err_range = 1'b1;
    end
    if (last_at_end) sb.push_back(e);
    foreach (d[i]) begin
      send(d[i], last_at_end && (i == d.size() - 1), st);
      if (i == 0) first_stall = st;
    end
  endtask

  // Wait for a path and take it with m_ready high; returns #1 after the handshake edge.
  task automatic recv(output res_t got, output bit ok);
    int w = 0;
    ok = 1'b1;
    while (m_valid !== 1'b1) begin
      @(negedge clk);
      if (m_valid === 1'b1) break;
      if (++w > BOUND) begin ok = 1'b0; break; end
    end
    got = {m_path, m_depth, m_err_range, m_err_len};
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_digit = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b need 1", s_ready); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b need 0", m_valid); end
    n_checks++;
    if ({m_path, m_depth, m_err_range, m_err_len} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: path=%h depth=%0d er=%b el=%b need all 0", m_path, m_depth, m_err_range, m_err_len);
    end
    n_checks++;
    if (path_cnt !== '0) begin n_fail++; $display("FAIL reset_path_cnt: got %0d need 0", path_cnt); end
  endtask

  task automatic test_full_depth();
    res_t got, e;
    bit   ok;
    int   st;
    int   d[$] = '{0, 0, 0, 0, 0, 0, 0, 2, 2};
    sb.push_back({PW'({3'd4, 3'd2, 3'd2, 21'd0}), DW'(10), 1'b0, 1'b0});
    foreach (d[i]) send(d[i], 1'b0, st);
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b need 0", m_valid); end
    send(4, 1'b1, st);
    n_checks++;
    if ({m_valid, s_ready} !== 2'b10) begin
      n_fail++; $display("FAIL full_latency: m_valid=%b s_ready=%b need 1/0", m_valid, s_ready);
    end
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL full_path: got %h need %h ok=%b", got, e, ok); end
    exp_cnt++;
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL full_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    res_t got, e;
    bit   ok;
    send_path('{3}, 1'b1);
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL single_path: got %h need %h ok=%b", got, e, ok); end
    n_checks++;
    if ({m_valid, s_ready} !== 2'b01) begin
      n_fail++; $display("FAIL handoff_flags: m_valid=%b s_ready=%b need 0/1", m_valid, s_ready);
    end
    exp_cnt++;
    send_path('{1, 0}, 1'b1);
    n_checks++;
    if (first_stall !== 0) begin n_fail++; $display("FAIL resume_stall: got %0d stalls need 0", first_stall); end
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL b2b_path: got %h need %h ok=%b", got, e, ok); end
    exp_cnt++;
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  task automatic test_range_err();
    res_t got, e;
    bit   ok;
    send_path('{1, 4, 6, 0}, 1'b1);
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e || got.err_range !== 1'b1) begin
      n_fail++; $display("FAIL range_path: got %h need %h ok=%b", got, e, ok);
    end
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL range_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  task automatic test_len_err();
    res_t got, e;
    bit   ok;
    int   d[$];
    for (int i = 0; i < 12; i++) d.push_back((i * 3 + 1) % FANOUT);
    send_path(d, 1'b1);
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e || got.err_len !== 1'b1 || got.depth !== DW'(DEPTH)) begin
      n_fail++; $display("FAIL len_path: got %h need %h ok=%b", got, e, ok);
    end
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL len_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  task automatic test_hold_backpressure();
    res_t got, e, snap;
    bit   ok;
    int   bad = 0;
    m_ready = 1'b0;
    send_path('{2, 1}, 1'b1);
    s_valid = 1'b1; s_digit = 3'd4; s_last = 1'b0;
    @(negedge clk);
    snap = {m_path, m_depth, m_err_range, m_err_len};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({m_valid, s_ready} !== 2'b10 || {m_path, m_depth, m_err_range, m_err_len} !== snap) begin
        n_fail++; bad++;
        if (bad < 4) $display("FAIL hold_stable: cycle %0d m_valid=%b s_ready=%b out=%h need 1/0 %h", i, m_valid, s_ready,
                              {m_path, m_depth, m_err_range, m_err_len}, snap);
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (snap !== e) begin n_fail++; $display("FAIL hold_path: got %h need %h", snap, e); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({m_valid, s_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hold_release: m_valid=%b s_ready=%b need 0/1", m_valid, s_ready);
    end
    exp_cnt++;
    send_path('{4, 1}, 1'b1);
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL resume_path: got %h need %h ok=%b", got, e, ok); end
    exp_cnt++;
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL resume_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_path();
    res_t got, e;
    bit   ok;
    send_path('{3, 3, 2, 1, 4}, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    n_checks++;
    if ({s_ready, m_valid, m_path, m_depth, m_err_range, m_err_len, path_cnt} !== {1'b1, {(PW + DW + CNT_W + 3){1'b0}}}) begin
      n_fail++; $display("FAIL midrst_outputs: rdy=%b vld=%b path=%h depth=%0d cnt=%0d need 1/0/0/0/0",
                         s_ready, m_valid, m_path, m_depth, path_cnt);
    end
    send_path('{2, 3, 1}, 1'b1);
    recv(got, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL midrst_path: got %h need %h ok=%b", got, e, ok); end
    exp_cnt++;
    n_checks++;
    if (path_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL midrst_cnt: got %0d need %0d", path_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_depth();
    test_back_to_back();
    test_range_err();
    test_len_err();
    test_hold_backpressure();
    test_reset_mid_path();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d entries need 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
